chain_ena_sequencer: RTL and testbench
======================================

Name: chain_ena_sequencer

Overview:
Sequences a one-hot enable token down an enable chain of CHAIN_LENGTH+1 stages, indices 0..CHAIN_LENGTH inclusive.
Each stage holds its enable for a programmable dwell time. Start, busy and done form a simple handshake; abort cancels the run.
Sits beside the chain datapath and drives each stage's ena directly, replacing ad-hoc prev-to-next ena assignments.

Parameters:
CHAIN_LENGTH, 4, index of the last chain stage; the chain has CHAIN_LENGTH+1 stages.
DWELL_W, 8, width of the dwell-time input.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active high.
start  input  1  request a sequence run; sampled only in IDLE.
dwell  input  DWELL_W  cycles each stage stays enabled; captured at accepted start; 0 is treated as 1.
abort  input  1  cancel the run in progress; sampled only in RUN.
ena  output  CHAIN_LENGTH+1  one-hot stage enables; bit i drives stage i.
stage_idx  output  $clog2(CHAIN_LENGTH+1)  index of the currently enabled stage; 0 when not in RUN.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset: rst=1 at an edge forces IDLE on that edge. Reset values: ena=0, stage_idx=0, busy=0, done=0, internal counter=0. rst has priority over start and abort.
- All outputs are registered.
- States:
  - IDLE: outputs at reset values. start=1 -> RUN. At the same edge: dwell is latched (0 becomes 1), stage=0, cnt=D-1.
  - RUN: ena=1<<stage, busy=1. Each cycle:
    - cnt!=0: cnt decrements.
    - cnt==0 and stage<CHAIN_LENGTH: stage increments and cnt reloads to D-1.
    - cnt==0 and stage==CHAIN_LENGTH: go to DONE.
  - DONE: ena=0, done=1, busy=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k. Stage i is enabled during cycles k+1+i*D through k+(i+1)*D. done is high in cycle k+1+(CHAIN_LENGTH+1)*D.
- ena is never multi-hot. There is no gap cycle between adjacent stages.
- abort=1 in RUN: next edge goes to IDLE. ena=0 and busy=0 from the next cycle; done is not pulsed. abort and cnt==0 in the same cycle: abort wins.
- start while busy (RUN or DONE) is ignored; it is not queued.
- start in the cycle after DONE, i.e. in IDLE, is accepted normally.
- abort in IDLE or DONE is ignored.
- dwell changes after acceptance have no effect on the current run.
- Counter width is DWELL_W. Reload D-1 with D=2^DWELL_W-1 must not overflow.

Decomposition:
- Package chain_seq_pkg holds:
  - state enum: IDLE, RUN, DONE;
  - localparam for the stage index width, $clog2(CHAIN_LENGTH+1);
  - the dwell typedef, logic [DWELL_W-1:0].
- One natural sub-module: chain_dwell_cnt.
  - Loadable down-counter with load, dec and zero flag.
  - Instanced once.
- FSM, stage index register and one-hot decode stay in the top module.

Test Plan:
- Normal run: CHAIN_LENGTH=4, dwell=3, start at cycle 0 -> ena=00001 in cycles 1-3, 00010 in 4-6, 00100 in 7-9, 01000 in 10-12, 10000 in 13-15; done=1 in cycle 16 only; busy high in cycles 1-16.
- Zero dwell: dwell=0, start at cycle 0 -> each stage enabled for 1 cycle (cycles 1-5); done in cycle 6.
- Abort: dwell=3, abort asserted in cycle 8 (stage 2) -> ena=0, busy=0, stage_idx=0 from cycle 9; done never pulses.
- Start while busy: start pulsed in cycles 5 and 16 of the normal run -> timing identical to the normal run. A start in cycle 17 (IDLE) begins a new run with ena[0] in cycle 18.
- Reset mid-operation: rst=1 in cycle 7 of the normal run -> all outputs 0 from cycle 8; a start in the same cycle as rst is ignored.
- Dwell change: dwell=2 at start, then dwell=7 during the run -> each stage still enabled for 2 cycles.

Source files
------------

// File: rtl/chain_seq_pkg.sv
// chain_seq_pkg: shared state encoding, default geometry and dwell type for the enable-chain sequencer
package chain_seq_pkg;
  localparam int DEF_CHAIN_LENGTH = 4;
  localparam int DEF_DWELL_W = 8;
  localparam int STAGE_W = $clog2(DEF_CHAIN_LENGTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [DEF_DWELL_W-1:0] dwell_t;
endpackage

// File: rtl/chain_dwell_cnt.sv
// chain_dwell_cnt: loadable down-counter timing how long the current stage stays enabled
module chain_dwell_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/chain_ena_sequencer.sv
// chain_ena_sequencer: walks a one-hot enable token across CHAIN_LENGTH+1 stages, each held for a latched dwell
module chain_ena_sequencer
  import chain_seq_pkg::*;
#(
  parameter int CHAIN_LENGTH = DEF_CHAIN_LENGTH,
  parameter int DWELL_W = DEF_DWELL_W,
  localparam int N = CHAIN_LENGTH + 1,
  localparam int SW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  output logic [N-1:0]       ena,
  output logic [SW-1:0]      stage_idx,
  output logic               busy,
  output logic               done
);
  state_t state, state_n;
  logic [SW-1:0] stage_n;
  logic [DWELL_W-1:0] dm1, ld_val;
  logic load, dec, zero;
  // dwell of 0 runs as 1, so the reload value saturates at 0 instead of wrapping
  assign ld_val = (state == IDLE) ? ((dwell == '0) ? '0 : dwell - DWELL_W'(1)) : dm1;
  always_comb begin
    state_n = state;
    stage_n = stage_idx;
    load = 1'b0;
    dec = 1'b0;
    case (state)
      IDLE: begin
        state_n = start ? RUN : IDLE;
        stage_n = '0;
        load = start;
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          stage_n = '0;
        end else if (!zero) dec = 1'b1;
        else if (stage_idx < SW'(CHAIN_LENGTH)) begin
          stage_n = stage_idx + SW'(1);
          load = 1'b1;
        end else begin
          state_n = DONE;
          stage_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        stage_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stage_idx <= '0;
      dm1 <= '0;
      ena <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      stage_idx <= stage_n;
      if (state == IDLE && start) dm1 <= ld_val;
      ena <= (state_n == RUN) ? N'(1) << stage_n : '0;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
    end
  end
  chain_dwell_cnt #(.W(DWELL_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(load),
    .dec(dec),
    .val(ld_val),
    .zero(zero)
  );
endmodule

// File: tb/tb_chain_ena_sequencer.sv
// tb_chain_ena_sequencer: directed checks of run timing, zero/max dwell, abort, busy-start, reset and dwell latching
module tb_chain_ena_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic [4:0] ena;
  logic [2:0] stage_idx;
  logic busy, done;
  int checks = 0;
  int failures = 0;
  chain_ena_sequencer dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dwell(dwell),
    .abort(abort),
    .ena(ena),
    .stage_idx(stage_idx),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input int n);
    chk({tag, "_ena"}, n, 32'(ena), 32'd0);
    chk({tag, "_stage"}, n, 32'(stage_idx), 32'd0);
    chk({tag, "_busy"}, n, 32'(busy), 32'd0);
    chk({tag, "_done"}, n, 32'(done), 32'd0);
  endtask
  // expected outputs in cycle n after a start accepted at edge 0 with effective dwell d
  task automatic chk_run(input string tag, input int n, input int d);
    int s;
    logic in_run;
    in_run = n >= 1 && n <= 5 * d;
    s = in_run ? (n - 1) / d : 0;
    chk({tag, "_ena"}, n, 32'(ena), in_run ? 32'd1 << s : 32'd0);
    chk({tag, "_stage"}, n, 32'(stage_idx), 32'(s));
    chk({tag, "_busy"}, n, 32'(busy), 32'(n >= 1 && n <= 5 * d + 1));
    chk({tag, "_done"}, n, 32'(done), 32'(n == 5 * d + 1));
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset", 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort_idle", 0);
    // normal run, dwell 3, with ignored starts in cycles 5 and 16
    dwell = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      chk_run("normal", n, 3);
      start = (n == 5 || n == 16);
      if (n == 16) abort = 1'b1;
      if (n == 17) start = 1'b1;
      tick();
      abort = 1'b0;
    end
    start = 1'b0;
    chk("restart_ena", 18, 32'(ena), 32'd1);
    chk("restart_busy", 18, 32'(busy), 32'd1);
    // that restart is run cycle 1; abort it in run cycle 8 (stage 2)
    for (int n = 2; n <= 8; n++) begin
      tick();
      chk_run("pre_abort", n, 3);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int n = 9; n <= 20; n++) begin
      chk_idle("aborted", n);
      tick();
    end
    // zero dwell behaves as one
    dwell = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      chk_run("zero", n, 1);
      tick();
    end
    // dwell changes after start are ignored
    dwell = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    dwell = 8'd7;
    for (int n = 1; n <= 12; n++) begin
      chk_run("dchg", n, 2);
      tick();
    end
    // reset mid-run with a simultaneous start
    dwell = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      chk_run("prerst", n, 3);
      if (n < 7) tick();
    end
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk_idle("rst_mid", 8);
    tick();
    chk_idle("rst_after", 9);
    // maximum dwell must not overflow the reload
    dwell = 8'd255;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 5 * 255 + 2; n++) begin
      if (n <= 2 || (n % 255) <= 1 || n >= 5 * 255) chk_run("max", n, 255);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
